// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory requesters, decode's scoreboard
// queries and the register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_xd;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_xd;
  logic [4:0]      rd;
  logic [XLEN-1:0] xd;
  logic            rd_en;
  logic            sb_set_en;
  logic [4:0]      sb_set_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;

  modport master (
    output alu_valid, alu_rd, alu_xd, mem_valid, mem_rd, mem_xd,
    output sb_set_en, sb_set_rd, rs1, rs2,
    input  alu_ready, mem_ready, rd, xd, rd_en, rs1_busy, rs2_busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_xd, mem_valid, mem_rd, mem_xd,
    input  sb_set_en, sb_set_rd, rs1, rs2,
    output alu_ready, mem_ready, rd, xd, rd_en, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter (mem priority, ALU anti-starvation) with a
// pending-write scoreboard. Optional macro WB_BYPASS_EN masks busy on same-cycle writeback.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= MAX_WAIT_C) ? MAX_WAIT_C : v + 4'd1;
  endfunction

  function automatic logic [31:0] onehot(input logic [4:0] r);
    return 32'b1 << r;
  endfunction

  logic [3:0]      wait_q, wait_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] xd_q, xd_d;
  logic            rd_en_q, rd_en_d;
  logic [31:0]     pend_q, pend_d;

  logic            alu_gnt, mem_gnt, xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_xd;
  logic [31:0]     set_vec, clr_vec;
  logic            rs1_fwd, rs2_fwd;

  // Grant: ALU wins only when alone or after being refused MAX_WAIT times
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (!reset) begin
      if (bus.alu_valid && (!bus.mem_valid || wait_q == MAX_WAIT_C))
        alu_gnt = 1'b1;
      else if (bus.mem_valid)
        mem_gnt = 1'b1;
    end
  end

  assign xfer   = alu_gnt | mem_gnt;
  assign sel_rd = alu_gnt ? bus.alu_rd : bus.mem_rd;
  assign sel_xd = alu_gnt ? bus.alu_xd : bus.mem_xd;

  always_comb begin
    wait_d  = 4'd0;
    rd_d    = rd_q;
    xd_d    = xd_q;
    rd_en_d = 1'b0;
    if (bus.alu_valid && !alu_gnt)
      wait_d = sat_inc(wait_q);
    if (xfer) begin
      rd_d    = sel_rd;
      xd_d    = sel_xd;
      rd_en_d = (sel_rd != 5'd0);
    end
  end

  // A fresh issue to the same register outranks the retiring write
  always_comb begin
    set_vec = bus.sb_set_en ? onehot(bus.sb_set_rd) : 32'd0;
    clr_vec = rd_en_q ? onehot(rd_q) : 32'd0;
    pend_d  = ((pend_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q  <= 4'd0;
      rd_q    <= 5'd0;
      xd_q    <= '0;
      rd_en_q <= 1'b0;
      pend_q  <= 32'd0;
    end else begin
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      xd_q    <= xd_d;
      rd_en_q <= rd_en_d;
      pend_q  <= pend_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Write-through register file lets decode read the value being written now
  assign rs1_fwd = rd_en_q && (rd_q == bus.rs1) && !(bus.sb_set_en && bus.sb_set_rd == bus.rs1);
  assign rs2_fwd = rd_en_q && (rd_q == bus.rs2) && !(bus.sb_set_en && bus.sb_set_rd == bus.rs2);
`else
  assign rs1_fwd = 1'b0;
  assign rs2_fwd = 1'b0;
`endif

  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;
  assign bus.rd        = rd_q;
  assign bus.xd        = xd_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rs1_busy  = pend_q[bus.rs1] && !rs1_fwd;
  assign bus.rs2_busy  = pend_q[bus.rs2] && !rs2_fwd;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed table, starvation and
// reset sequences, then random traffic against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_s;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) ifc ();

  regfile_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (rst_s),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] axd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mxd;
    logic        sbe;
    logic [4:0]  sbr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ar;
    logic        e_mr;
    logic        e_b1;
    logic        e_en;
    logic        chk;
    logic [4:0]  e_rd;
    logic [31:0] e_xd;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] axd,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] mxd,
                              input logic sbe, input logic [4:0] sbr,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic e_ar, input logic e_mr, input logic e_b1,
                              input logic e_en, input logic chk,
                              input logic [4:0] e_rd, input logic [31:0] e_xd);
    vec_t v;
    v.av = av; v.ard = ard; v.axd = axd; v.mv = mv; v.mrd = mrd; v.mxd = mxd;
    v.sbe = sbe; v.sbr = sbr; v.r1 = r1; v.r2 = r2;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_b1 = e_b1; v.e_en = e_en; v.chk = chk;
    v.e_rd = e_rd; v.e_xd = e_xd;
    return v;
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  bit          pend_m[32];
  int          waits_m;
  logic        en_m;
  logic [4:0]  rd_m;
  logic [31:0] xd_m;
  bit          known_m;

  logic        obs_ar, obs_mr, obs_b1, obs_b2, obs_en;
  logic [4:0]  obs_rd;
  logic [31:0] obs_xd;

  function automatic logic busy_m(input logic [4:0] rs, input logic sbe, input logic [4:0] sbr);
    logic b;
    b = pend_m[rs];
`ifdef WB_BYPASS_EN
    if (en_m && rd_m == rs && !(sbe && sbr == rs)) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic step(input vec_t v, input logic rst_v);
    logic        g_alu, g_mem, eb1, eb2;
    logic [4:0]  grd;
    logic [31:0] gxd;
    rst_s         = rst_v;
    ifc.alu_valid = v.av;  ifc.alu_rd = v.ard; ifc.alu_xd = v.axd;
    ifc.mem_valid = v.mv;  ifc.mem_rd = v.mrd; ifc.mem_xd = v.mxd;
    ifc.sb_set_en = v.sbe; ifc.sb_set_rd = v.sbr;
    ifc.rs1 = v.r1; ifc.rs2 = v.r2;
    #2;
    g_alu = !rst_v && v.av && (!v.mv || waits_m >= MAX_WAIT);
    g_mem = !rst_v && v.mv && !g_alu;
    eb1 = busy_m(v.r1, v.sbe, v.sbr);
    eb2 = busy_m(v.r2, v.sbe, v.sbr);
    obs_ar = ifc.alu_ready; obs_mr = ifc.mem_ready;
    obs_b1 = ifc.rs1_busy;  obs_b2 = ifc.rs2_busy;
    chk("alu_ready", {31'd0, obs_ar}, {31'd0, g_alu});
    chk("mem_ready", {31'd0, obs_mr}, {31'd0, g_mem});
    if (!rst_v) begin
      chk("rs1_busy", {31'd0, obs_b1}, {31'd0, eb1});
      chk("rs2_busy", {31'd0, obs_b2}, {31'd0, eb2});
    end
    @(posedge clk);
    if (rst_v) begin
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      waits_m = 0; en_m = 1'b0; rd_m = 5'd0; xd_m = 32'd0; known_m = 1'b1;
    end else begin
      if (en_m) pend_m[rd_m] = 1'b0;
      if (v.sbe && v.sbr != 5'd0) pend_m[v.sbr] = 1'b1;
      if (v.av && !g_alu) waits_m = (waits_m + 1 > MAX_WAIT) ? MAX_WAIT : waits_m + 1;
      else waits_m = 0;
      grd = g_alu ? v.ard : v.mrd;
      gxd = g_alu ? v.axd : v.mxd;
      en_m = (g_alu || g_mem) && grd != 5'd0;
      if (en_m) begin
        rd_m = grd; xd_m = gxd; known_m = 1'b1;
      end else if (g_alu || g_mem) begin
        known_m = 1'b0;
      end
    end
    #1;
    obs_en = ifc.rd_en; obs_rd = ifc.rd; obs_xd = ifc.xd;
    chk("rd_en", {31'd0, obs_en}, {31'd0, en_m});
    if (known_m) begin
      chk("rd", {27'd0, obs_rd}, {27'd0, rd_m});
      chk("xd", obs_xd, xd_m);
    end
  endtask

  vec_t tbl[12];
  vec_t idle, rv;

  initial begin
    logic byp_b1;
`ifdef WB_BYPASS_EN
    byp_b1 = 1'b0;
`else
    byp_b1 = 1'b1;
`endif
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    waits_m = 0; en_m = 1'b0; rd_m = 5'd0; xd_m = 32'd0; known_m = 1'b1;

    idle = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 0,0,0,0);
    //          av ard axd           mv mrd mxd          sbe sbr r1 r2 ar mr b1      en chk rd xd
    tbl[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  2, 0, 0, 0, 0,      0, 1, 0, 32'h0);
    tbl[1]  = mk(1, 3, 32'hcacac01a, 0, 0, 32'h0,        0, 0,  2, 0, 1, 0, 0,      1, 1, 3, 32'hcacac01a);
    tbl[2]  = mk(0, 0, 32'h0,        1, 0, 32'hc0cac01a, 0, 0,  2, 0, 0, 1, 0,      0, 0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 2,  2, 0, 0, 0, 0,      0, 0, 0, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  2, 0, 0, 0, 1,      0, 0, 0, 32'h0);
    tbl[5]  = mk(1, 2, 32'h11,       0, 0, 32'h0,        0, 0,  2, 0, 1, 0, 1,      1, 1, 2, 32'h11);
    tbl[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  2, 0, 0, 0, byp_b1, 0, 1, 2, 32'h11);
    tbl[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  2, 0, 0, 0, 0,      0, 1, 2, 32'h11);
    tbl[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 5,  5, 0, 0, 0, 0,      0, 1, 2, 32'h11);
    tbl[9]  = mk(1, 5, 32'h55,       0, 0, 32'h0,        0, 0,  5, 0, 1, 0, 1,      1, 1, 5, 32'h55);
    tbl[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 5,  5, 0, 0, 0, 1,      0, 1, 5, 32'h55);
    tbl[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  5, 0, 0, 0, 1,      0, 1, 5, 32'h55);

    // Reset with no requests
    step(idle, 1'b1);
    step(idle, 1'b1);
    chk("reset_alu_ready", {31'd0, obs_ar}, 32'd0);
    chk("reset_mem_ready", {31'd0, obs_mr}, 32'd0);
    chk("reset_rd_en", {31'd0, obs_en}, 32'd0);
    chk("reset_rd", {27'd0, obs_rd}, 32'd0);
    chk("reset_xd", obs_xd, 32'd0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i], 1'b0);
      chk($sformatf("tbl%0d_alu_ready", i), {31'd0, obs_ar}, {31'd0, tbl[i].e_ar});
      chk($sformatf("tbl%0d_mem_ready", i), {31'd0, obs_mr}, {31'd0, tbl[i].e_mr});
      chk($sformatf("tbl%0d_rs1_busy", i), {31'd0, obs_b1}, {31'd0, tbl[i].e_b1});
      chk($sformatf("tbl%0d_rs2_busy", i), {31'd0, obs_b2}, 32'd0);
      chk($sformatf("tbl%0d_rd_en", i), {31'd0, obs_en}, {31'd0, tbl[i].e_en});
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_rd", i), {27'd0, obs_rd}, {27'd0, tbl[i].e_rd});
        chk($sformatf("tbl%0d_xd", i), obs_xd, tbl[i].e_xd);
      end
    end

    // Both requesters held: mem wins MAX_WAIT times, then ALU, then mem again
    for (int i = 0; i < MAX_WAIT + 2; i++) begin
      logic exp_alu;
      exp_alu = (i == MAX_WAIT);
      step(mk(1, 5'(10 + i), 32'(32'h100 + i), 1, 5'(20 + i), 32'(32'h200 + i),
              0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      chk($sformatf("starve%0d_alu_ready", i), {31'd0, obs_ar}, {31'd0, exp_alu});
      chk($sformatf("starve%0d_mem_ready", i), {31'd0, obs_mr}, {31'd0, !exp_alu});
      chk($sformatf("starve%0d_rd", i), {27'd0, obs_rd}, exp_alu ? 32'(10 + i) : 32'(20 + i));
    end

    // Mid-run reset clears pending bits and suppresses the write
    step(mk(0,0,0, 0,0,0, 1,7, 0,0, 0,0,0,0,0,0,0), 1'b0);
    step(mk(0,0,0, 0,0,0, 1,8, 0,0, 0,0,0,0,0,0,0), 1'b0);
    step(mk(0,0,0, 0,0,0, 1,9, 7,9, 0,0,0,0,0,0,0), 1'b0);
    step(mk(1,7,32'h77, 0,0,0, 0,0, 7,9, 0,0,0,0,0,0,0), 1'b1);
    chk("midreset_alu_ready", {31'd0, obs_ar}, 32'd0);
    chk("midreset_rd_en", {31'd0, obs_en}, 32'd0);
    step(mk(0,0,0, 0,0,0, 0,0, 7,9, 0,0,0,0,0,0,0), 1'b0);
    chk("midreset_rs1_busy", {31'd0, obs_b1}, 32'd0);
    chk("midreset_rs2_busy", {31'd0, obs_b2}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rv = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 1) != 0, 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              0, 0, 0, 0, 0, 0, 0);
      step(rv, $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
